dpi_stream_feeder: RTL and testbench

//  Transmit side of the per-stream matcher interface. Takes packets (flow-key header, then payload bytes).

---
 rtl/dpi_stream_feeder.sv | 176 +++++++++++++++++
 tb/tb_dpi_stream_feeder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : dpi_stream_feeder
// Purpose  : Maps packet flow keys to stream ids and feeds the payload bytes
//            to the per-stream matchers. Optional stats: DPI_FEEDER_STATS_EN
// Revision : 1.0
// ============================================================================
module dpi_stream_feeder #(
    parameter int KEY_W       = 32,
    parameter int NUM_STREAMS = 64,
    parameter int SID_W       = 6,
    parameter int LOAD_GAP    = 2,
    parameter int EOP_GAP     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hdr_vld,
    input  logic [KEY_W-1:0] hdr_key,
    output logic             hdr_rdy,
    input  logic             byte_vld,
    input  logic [7:0]       byte_data,
    input  logic             byte_last,
    output logic             byte_rdy,
    output logic             load_state,
    output logic [SID_W-1:0] stream_id,
    output logic             new_stream_id,
    output logic [7:0]       char_in,
    output logic             char_in_vld,
    output logic             eop,
    output logic             busy,
    output logic             evict
`ifdef DPI_FEEDER_STATS_EN
    ,
    output logic [31:0]      pkt_cnt,
    output logic [31:0]      byte_cnt,
    output logic [15:0]      evict_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_LOAD   = 3'd2,
        S_LGAP   = 3'd3,
        S_STREAM = 3'd4,
        S_DRAIN  = 3'd5,
        S_EOP    = 3'd6
    } state_t;

    localparam int               GAP_W     = $clog2(LOAD_GAP + EOP_GAP + 2);
    // The first STREAM cycle is itself idle on char_in_vld, so LGAP is one
    // cycle shorter than LOAD_GAP; DRAIN starts with the final char still
    // valid, so it lasts one cycle longer than EOP_GAP.
    localparam logic [GAP_W-1:0] LGAP_END  = GAP_W'(LOAD_GAP - 2);
    localparam logic [GAP_W-1:0] DRAIN_END = GAP_W'(EOP_GAP);
    localparam logic [SID_W-1:0] LAST_IDX  = SID_W'(NUM_STREAMS - 1);

    state_t             state;
    state_t             next_state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [KEY_W-1:0]   key_q;
    logic [SID_W-1:0]   idx;
    logic [SID_W-1:0]   alloc_ptr;
    logic [KEY_W-1:0]   tbl_key [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] tbl_vld;
    logic               lookup_hit;
    logic               alloc;
    logic               hdr_fire;
    logic               byte_fire;

    assign hdr_fire  = hdr_vld & hdr_rdy;
    assign byte_fire = byte_vld & byte_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        lookup_hit = 1'b0;
        alloc      = 1'b0;
        case (state)
            S_IDLE:   if (hdr_fire) next_state = S_LOOKUP;
            S_LOOKUP: begin
                lookup_hit = tbl_vld[idx] && (tbl_key[idx] == key_q);
                if (lookup_hit) begin
                    next_state = S_LOAD;
                end else if (idx == LAST_IDX) begin
                    alloc      = 1'b1;
                    next_state = S_LOAD;
                end
            end
            S_LOAD:   next_state = S_LGAP;
            S_LGAP:   if (gap_cnt == LGAP_END) next_state = S_STREAM;
            S_STREAM: if (byte_fire && byte_last) next_state = S_DRAIN;
            S_DRAIN:  if (gap_cnt == DRAIN_END) next_state = S_EOP;
            S_EOP:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Key storage carries no reset; tbl_vld alone qualifies an entry.
    always_ff @(posedge clk) begin
        if (alloc) tbl_key[alloc_ptr] <= key_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt       <= '0;
            key_q         <= '0;
            idx           <= '0;
            alloc_ptr     <= '0;
            tbl_vld       <= '0;
            hdr_rdy       <= 1'b0;
            byte_rdy      <= 1'b0;
            load_state    <= 1'b0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            busy          <= 1'b0;
            evict         <= 1'b0;
        end else begin
            gap_cnt <= (next_state != state) ? '0 : gap_cnt + 1'b1;

            if (hdr_fire) begin
                key_q <= hdr_key;
                idx   <= '0;
            end else if (state == S_LOOKUP) begin
                idx <= idx + 1'b1;
            end

            if (lookup_hit) begin
                stream_id     <= idx;
                new_stream_id <= 1'b0;
            end
            if (alloc) begin
                stream_id          <= alloc_ptr;
                new_stream_id      <= 1'b1;
                tbl_vld[alloc_ptr] <= 1'b1;
                alloc_ptr          <= alloc_ptr + 1'b1;
            end
            evict <= alloc && tbl_vld[alloc_ptr];

            hdr_rdy    <= (next_state == S_IDLE);
            byte_rdy   <= (next_state == S_STREAM);
            load_state <= (next_state == S_LOAD);
            eop        <= (next_state == S_EOP);
            busy       <= (next_state != S_IDLE);

            char_in_vld <= byte_fire;
            if (byte_fire) char_in <= byte_data;
        end
    end

`ifdef DPI_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt   <= '0;
            byte_cnt  <= '0;
            evict_cnt <= '0;
        end else begin
            if (eop)         pkt_cnt  <= pkt_cnt + 32'd1;
            if (char_in_vld) byte_cnt <= byte_cnt + 32'd1;
            if (evict && (evict_cnt != 16'hFFFF)) evict_cnt <= evict_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpi_stream_feeder.sv
`default_nettype none
// Testbench for dpi_stream_feeder: vector table, hand-written corner sequences
// and a randomized run checked against a key->stream map model.
module tb_dpi_stream_feeder;

    localparam int LOAD_GAP = 2;
    localparam int EOP_GAP  = 3;
    localparam int NS       = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hdr_vld = 1'b0;
    logic [31:0] hdr_key = '0;
    logic        hdr_rdy;
    logic        byte_vld = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_last = 1'b0;
    logic        byte_rdy;
    logic        load_state;
    logic [5:0]  stream_id;
    logic        new_stream_id;
    logic [7:0]  char_in;
    logic        char_in_vld;
    logic        eop;
    logic        busy;
    logic        evict;
`ifdef DPI_FEEDER_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] byte_cnt;
    logic [15:0] evict_cnt;
`endif

    always #5 clk = ~clk;

    dpi_stream_feeder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hdr_vld       (hdr_vld),
        .hdr_key       (hdr_key),
        .hdr_rdy       (hdr_rdy),
        .byte_vld      (byte_vld),
        .byte_data     (byte_data),
        .byte_last     (byte_last),
        .byte_rdy      (byte_rdy),
        .load_state    (load_state),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .char_in       (char_in),
        .char_in_vld   (char_in_vld),
        .eop           (eop),
        .busy          (busy),
        .evict         (evict)
`ifdef DPI_FEEDER_STATS_EN
        ,
        .pkt_cnt       (pkt_cnt),
        .byte_cnt      (byte_cnt),
        .evict_cnt     (evict_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  payload [$];
    logic [31:0] seen [$];

    // Reference model: key -> stream map, owner of each stream, round-robin pointer
    int          m_map [logic [31:0]];
    logic [31:0] m_owner [NS];
    bit          m_used [NS];
    int          m_ptr;
    int          m_pkts;
    int          m_bytes;
    int          m_evicts;

    typedef struct {
        logic [31:0] key;
        int          n;
        int          mode;
        bit          get;
        int          sid;
        bit          nw;
        bit          ev;
        int          lk;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_map.delete();
        for (int i = 0; i < NS; i++) m_used[i] = 1'b0;
        m_ptr = 0; m_pkts = 0; m_bytes = 0; m_evicts = 0;
    endtask

    task automatic model_lookup(input logic [31:0] key, output int sid, output bit nw,
                                output bit ev, output int lk);
        if (m_map.exists(key)) begin
            sid = m_map[key]; nw = 1'b0; ev = 1'b0; lk = sid + 1;
        end else begin
            sid = m_ptr; nw = 1'b1; ev = m_used[sid];
            if (ev) begin
                m_map.delete(m_owner[sid]);
                m_evicts++;
            end
            m_owner[sid] = key; m_used[sid] = 1'b1; m_map[key] = sid;
            m_ptr = (m_ptr + 1) % NS; lk = NS;
        end
    endtask

    task automatic make_payload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    // mode 0: back-to-back bytes, 1: bubble after every byte, 2: random bubbles
    task automatic run_pkt(input logic [31:0] key, input int mode, input bit hold,
                           input logic [31:0] hold_key, input int exp_sid,
                           input bit exp_new, input bit exp_ev, input int exp_lk);
        int cyc, k, first, last, eop_k, eop_n, extra, i, n;
        bit bub, hdr_bad, id_ok, same;
        logic [7:0] got [$];
        n = payload.size();
        cyc = 0;
        while (!hdr_rdy && cyc < 300) begin @(negedge clk); cyc++; end
        hdr_vld = 1'b1; hdr_key = key;
        @(negedge clk);
        hdr_vld = hold;
        if (hold) hdr_key = hold_key;
        cyc = 0;
        while (!load_state && cyc < 300) begin cyc++; @(negedge clk); end
        check("lookup_cycles", cyc, exp_lk);
        check("stream_id", stream_id, exp_sid);
        check("new_stream_id", new_stream_id, exp_new);
        check("evict", evict, exp_ev);
        k = 0; first = -1; last = -1; eop_k = -1; eop_n = 0; extra = 0; i = 0;
        bub = 1'b0; hdr_bad = 1'b0; id_ok = 1'b0;
        while (k < 600) begin
            if (k > 0 && (load_state || evict)) extra++;
            if (char_in_vld) begin
                got.push_back(char_in);
                if (first < 0) first = k;
                last = k;
            end
            if (eop) begin
                eop_n++;
                if (eop_k < 0) begin
                    eop_k = k;
                    id_ok = (stream_id === 6'(exp_sid)) && (new_stream_id === exp_new);
                end
            end
            if (eop_k < 0 && hdr_rdy) hdr_bad = 1'b1;
            if (eop_k >= 0 && k == eop_k + 1) break;
            if (i < n) begin
                if (bub) begin
                    byte_vld = 1'b0; bub = 1'b0;
                end else begin
                    byte_vld = 1'b1; byte_data = payload[i]; byte_last = (i == n - 1);
                    if (byte_rdy) begin
                        i++;
                        bub = (mode == 1) || (mode == 2 && $urandom_range(0, 2) == 0);
                    end
                end
            end else begin
                byte_vld = 1'b0; byte_last = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        byte_vld = 1'b0; byte_last = 1'b0;
        if (!hold) hdr_vld = 1'b0;
        same = (got.size() == n);
        for (int j = 0; j < n && same; j++) same = (got[j] === payload[j]);
        check("first_char_gap", first - 1, LOAD_GAP);
        check("char_count", got.size(), n);
        check("char_data", same, 1'b1);
        if (mode != 2) check("char_span", last - first + 1, (mode == 1) ? 2 * n - 1 : n);
        check("eop_gap", eop_k - last - 1, EOP_GAP);
        check("eop_count", eop_n, 1);
        check("single_pulses", extra, 0);
        check("hdr_rdy_busy", hdr_bad, 1'b0);
        check("id_held_at_eop", id_ok, 1'b1);
        check("hdr_rdy_after_eop", hdr_rdy, 1'b1);
        m_pkts++;
        m_bytes += n;
    endtask

    task automatic run_model_pkt(input logic [31:0] key, input int mode);
        int sid, lk;
        bit nw, ev;
        model_lookup(key, sid, nw, ev, lk);
        run_pkt(key, mode, 1'b0, 32'h0, sid, nw, ev, lk);
    endtask

    function automatic logic [21:0] all_outs();
        return {hdr_rdy, byte_rdy, load_state, stream_id, new_stream_id,
                char_in, char_in_vld, eop, busy, evict};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; hdr_vld = 1'b0; byte_vld = 1'b0; byte_last = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 22'h0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sid, lk, cyc, acc, eops;
        bit nw, ev;
        logic [31:0] key;

        vecs[0] = '{key: 32'hA5A5_0001, n: 4, mode: 0, get: 1'b1, sid: 0, nw: 1'b1, ev: 1'b0, lk: 64};
        vecs[1] = '{key: 32'hA5A5_0001, n: 3, mode: 0, get: 1'b0, sid: 0, nw: 1'b0, ev: 1'b0, lk: 1};
        vecs[2] = '{key: 32'h0000_BEEF, n: 1, mode: 0, get: 1'b0, sid: 1, nw: 1'b1, ev: 1'b0, lk: 64};
        vecs[3] = '{key: 32'h0000_BEEF, n: 2, mode: 1, get: 1'b0, sid: 1, nw: 1'b0, ev: 1'b0, lk: 2};
        vecs[4] = '{key: 32'hA5A5_0001, n: 6, mode: 1, get: 1'b0, sid: 0, nw: 1'b0, ev: 1'b0, lk: 1};

        do_reset();

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].get) begin
                payload.delete();
                payload.push_back(8'h47); payload.push_back(8'h45);
                payload.push_back(8'h54); payload.push_back(8'h20);
            end else begin
                make_payload(vecs[v].n);
            end
            model_lookup(vecs[v].key, sid, nw, ev, lk);
            run_pkt(vecs[v].key, vecs[v].mode, 1'b0, 32'h0, vecs[v].sid,
                    vecs[v].nw, vecs[v].ev, vecs[v].lk);
        end
        seen.push_back(32'hA5A5_0001);
        seen.push_back(32'h0000_BEEF);

        // Bubbled 2-byte packet with the next header held high throughout
        make_payload(2);
        model_lookup(32'hC0DE_0004, sid, nw, ev, lk);
        run_pkt(32'hC0DE_0004, 1, 1'b1, 32'h0000_BEEF, 2, 1'b1, 1'b0, 64);
        make_payload(3);
        model_lookup(32'h0000_BEEF, sid, nw, ev, lk);
        run_pkt(32'h0000_BEEF, 0, 1'b0, 32'h0, 1, 1'b0, 1'b0, 2);
        seen.push_back(32'hC0DE_0004);

        // Randomized traffic: mix of repeated and fresh keys
        for (int p = 0; p < 100; p++) begin
            if ($urandom_range(0, 1) == 1) key = seen[$urandom_range(0, seen.size() - 1)];
            else begin
                key = $urandom();
                seen.push_back(key);
            end
            make_payload($urandom_range(1, 8));
            run_model_pkt(key, $urandom_range(0, 2));
        end

        // Table wrap: 65 distinct keys, then the first key has been evicted
        do_reset();
        for (int j = 1; j <= 64; j++) begin
            make_payload(1);
            run_model_pkt(32'h1000_0000 + 32'(j), 0);
        end
        make_payload(1);
        model_lookup(32'h1000_0041, sid, nw, ev, lk);
        run_pkt(32'h1000_0041, 0, 1'b0, 32'h0, 0, 1'b1, 1'b1, 64);
        make_payload(2);
        model_lookup(32'h1000_0001, sid, nw, ev, lk);
        run_pkt(32'h1000_0001, 0, 1'b0, 32'h0, 1, 1'b1, 1'b1, 64);
`ifdef DPI_FEEDER_STATS_EN
        check("evict_cnt", evict_cnt, m_evicts);
        check("pkt_cnt_wrap", pkt_cnt, m_pkts);
        check("byte_cnt_wrap", byte_cnt, m_bytes);
`endif

        // Asynchronous reset in the middle of a packet
        key = m_owner[5];
        model_lookup(key, sid, nw, ev, lk);
        cyc = 0;
        while (!hdr_rdy && cyc < 300) begin @(negedge clk); cyc++; end
        hdr_vld = 1'b1; hdr_key = key;
        @(negedge clk);
        hdr_vld = 1'b0;
        cyc = 0;
        while (!load_state && cyc < 300) begin cyc++; @(negedge clk); end
        check("rst_seq_sid", stream_id, 5);
        acc = 0; cyc = 0;
        while (acc < 2 && cyc < 50) begin
            byte_vld = 1'b1; byte_data = 8'h5A + 8'(acc); byte_last = 1'b0;
            if (byte_rdy) acc++;
            @(negedge clk);
            cyc++;
        end
        byte_vld = 1'b0;
        check("rst_seq_busy", busy, 1'b1);
        check("rst_seq_char", char_in_vld, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 22'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        eops = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (eop) eops++;
        end
        check("no_eop_after_abort", eops, 0);
        make_payload(2);
        model_lookup(32'h7777_0005, sid, nw, ev, lk);
        run_pkt(32'h7777_0005, 0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 64);

        // Three packets of 5, 1 and 10 bytes from a fresh reset
        do_reset();
        make_payload(5);
        run_model_pkt(32'h3000_0001, 2);
        make_payload(1);
        run_model_pkt(32'h3000_0002, 0);
        make_payload(10);
        run_model_pkt(32'h3000_0001, 1);
`ifdef DPI_FEEDER_STATS_EN
        check("pkt_cnt", pkt_cnt, 32'd3);
        check("byte_cnt", byte_cnt, 32'd16);
        check("evict_cnt_fresh", evict_cnt, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
